agc_gain_scheduler: RTL and testbench

AGC_GAIN_SCHEDULER -- requirements
Module: agc_gain_scheduler

---
 rtl/agc_pkg.sv | 11 +
 rtl/agc_gain_div.sv | 46 ++++
 rtl/agc_gain_scheduler.sv | 95 +++++++++
 tb/tb_agc_gain_scheduler.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// agc_pkg: shared AGC constants and FSM state encoding for the gain scheduler and datapath
// Contents: agc_state_t (IDLE/DIV/CLAMP/DONE), DIV_ITERS, Q15_W and default gain/level constants.
package agc_pkg;
    typedef enum logic [1:0] {IDLE, DIV, CLAMP, DONE} agc_state_t;
    localparam int DIV_ITERS      = 30;
    localparam int Q15_W          = 16;
    localparam int DEF_TARGET_Q15 = 29000;
    localparam int DEF_MAX_GAIN   = 32767;
    localparam int DEF_MIN_GAIN   = 8192;
    localparam int DEF_ENV_FLOOR  = 64;
endpackage

// File: rtl/agc_gain_div.sv
// agc_gain_div: serial restoring divider, one quotient bit per cycle over DIV_ITERS cycles
// Ports: clk, rst (sync, active-high); start loads dividend/divisor; done is high in the
// final iteration cycle; quotient is valid from the cycle after done until the next start.
module agc_gain_div
    import agc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIV_ITERS-1:0] dividend,
    input  logic [Q15_W-1:0]     divisor,
    output logic                 done,
    output logic [DIV_ITERS-1:0] quotient
);
    logic [Q15_W-1:0] rem;
    logic [Q15_W-1:0] dsr;
    logic [4:0]       cnt;
    logic [Q15_W:0]   trial;
    logic             fit;

    // quotient doubles as the dividend shift register: dividend bits leave at the top,
    // quotient bits enter at the bottom
    always_comb begin
        trial = {rem, quotient[DIV_ITERS-1]};
        fit   = trial >= {1'b0, dsr};
        done  = cnt == 5'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem      <= '0;
            dsr      <= '0;
            cnt      <= '0;
            quotient <= '0;
        end else if (start) begin
            rem      <= '0;
            dsr      <= divisor;
            cnt      <= 5'(DIV_ITERS);
            quotient <= dividend;
        end else if (cnt != 5'd0) begin
            cnt      <= cnt - 5'd1;
            rem      <= fit ? Q15_W'(trial - {1'b0, dsr}) : trial[Q15_W-1:0];
            quotient <= {quotient[DIV_ITERS-2:0], fit};
        end
    end
endmodule

// File: rtl/agc_gain_scheduler.sv
// agc_gain_scheduler: round-robin AGC gain computation, NUM_CH channels sharing one divider
// Ports: clk, rst (sync, active-high); env_valid/env_in per-channel envelope strobes (16b each,
// channel k at [16k+15:16k]); gain_out held Q1.15 gains (same packing); gain_valid one-cycle
// update pulse per channel; busy high whenever the FSM is not IDLE.
module agc_gain_scheduler
    import agc_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int TARGET_Q15   = DEF_TARGET_Q15,
    parameter int MAX_GAIN_Q15 = DEF_MAX_GAIN,
    parameter int MIN_GAIN_Q15 = DEF_MIN_GAIN,
    parameter int ENV_FLOOR    = DEF_ENV_FLOOR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       env_valid,
    input  logic [16*NUM_CH-1:0]    env_in,
    output logic [16*NUM_CH-1:0]    gain_out,
    output logic [NUM_CH-1:0]       gain_valid,
    output logic                    busy
);
    localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [DIV_ITERS-1:0] DIVIDEND = DIV_ITERS'(TARGET_Q15 * 32768);

    agc_state_t           state;
    logic [Q15_W-1:0]     slot [NUM_CH];
    logic [NUM_CH-1:0]    pending;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        cur;
    logic [PW-1:0]        gsel;
    logic [PW-1:0]        cand;
    logic                 grant;
    logic                 div_done;
    logic [Q15_W-1:0]     divisor;
    logic [Q15_W-1:0]     gain;
    logic [DIV_ITERS-1:0] quotient;

    // scanning offsets from high to low lets the smallest offset from rr_ptr win
    always_comb begin
        gsel = '0;
        cand = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = PW'((int'(rr_ptr) + i) % NUM_CH);
            if (pending[cand]) gsel = cand;
        end
        grant   = state == IDLE && |pending;
        divisor = slot[gsel] < Q15_W'(ENV_FLOOR) ? Q15_W'(ENV_FLOOR) : slot[gsel];
        gain    = quotient > DIV_ITERS'(MAX_GAIN_Q15) ? Q15_W'(MAX_GAIN_Q15) :
                  quotient < DIV_ITERS'(MIN_GAIN_Q15) ? Q15_W'(MIN_GAIN_Q15) :
                  quotient[Q15_W-1:0];
        busy    = state != IDLE;
    end

    agc_gain_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (grant),
        .dividend (DIVIDEND),
        .divisor  (divisor),
        .done     (div_done),
        .quotient (quotient)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            rr_ptr     <= '0;
            cur        <= '0;
            gain_out   <= {NUM_CH{Q15_W'(MAX_GAIN_Q15)}};
            gain_valid <= '0;
            for (int k = 0; k < NUM_CH; k++) slot[k] <= '0;
        end else begin
            gain_valid <= '0;
            for (int k = 0; k < NUM_CH; k++) if (env_valid[k]) slot[k] <= env_in[16*k +: 16];
            // a strobe in the grant cycle re-arms the granted channel
            pending <= env_valid | (pending & ~(grant ? NUM_CH'(1) << gsel : '0));
            case (state)
                IDLE: if (grant) begin
                    cur    <= gsel;
                    rr_ptr <= gsel == PW'(NUM_CH - 1) ? '0 : gsel + PW'(1);
                    state  <= DIV;
                end
                DIV: if (div_done) state <= CLAMP;
                // output registers load here so the update is visible during DONE
                CLAMP: begin
                    gain_out[16*cur +: 16] <= gain;
                    gain_valid[cur]        <= 1'b1;
                    state                  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_agc_gain_scheduler.sv
// tb_agc_gain_scheduler: scoreboard bench for agc_gain_scheduler (default and TARGET=8000 instances)
module tb_agc_gain_scheduler;
    typedef struct {int ch; int gain; int cyc;} exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic [1:0]  ev0 = 0, ev1 = 0;
    logic [31:0] ei0 = 0, ei1 = 0;
    logic [31:0] go0, go1;
    logic [1:0]  gv0, gv1;
    logic        bz0, bz1;
    int          cyc = 0;
    int          n_cmp = 0, n_bad = 0;
    exp_t        q0[$], q1[$];
    exp_t        m0, m1;
    int          hold0[2], hold1[2];
    int          t;
    logic        seen_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    agc_gain_scheduler u0 (
        .clk(clk), .rst(rst), .env_valid(ev0), .env_in(ei0),
        .gain_out(go0), .gain_valid(gv0), .busy(bz0)
    );

    agc_gain_scheduler #(.TARGET_Q15(8000)) u1 (
        .clk(clk), .rst(rst), .env_valid(ev1), .env_in(ei1),
        .gain_out(go1), .gain_valid(gv1), .busy(bz1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int model(input int target, input int env);
        longint d, q;
        d = env < 64 ? 64 : env;
        q = (longint'(target) * 32768) / d;
        return q > 32767 ? 32767 : q < 8192 ? 8192 : int'(q);
    endfunction

    task automatic strobe(input int dut, input logic [1:0] v, input int e0, input int e1, output int ts);
        @(posedge clk);
        #1;
        ts = cyc;
        if (dut == 0) begin ev0 = v; ei0 = {16'(e1), 16'(e0)}; end
        else begin ev1 = v; ei1 = {16'(e1), 16'(e0)}; end
        @(posedge clk);
        #1;
        ev0 = 0;
        ev1 = 0;
    endtask

    always @(negedge clk) if (!rst) for (int c = 0; c < 2; c++) if (gv0[c]) begin
        if (q0.size() == 0) chk("u0_unexpected_valid", c, -1);
        else begin
            m0 = q0.pop_front();
            chk("u0_channel", c, m0.ch);
            chk("u0_gain", int'(go0[16*c +: 16]), m0.gain);
            chk("u0_latency", cyc, m0.cyc);
            hold0[c] = m0.gain;
            chk("u0_held_gains", int'(go0), int'({16'(hold0[1]), 16'(hold0[0])}));
        end
    end

    always @(negedge clk) if (!rst) for (int c = 0; c < 2; c++) if (gv1[c]) begin
        if (q1.size() == 0) chk("u1_unexpected_valid", c, -1);
        else begin
            m1 = q1.pop_front();
            chk("u1_channel", c, m1.ch);
            chk("u1_gain", int'(go1[16*c +: 16]), m1.gain);
            chk("u1_latency", cyc, m1.cyc);
            hold1[c] = m1.gain;
        end
    end

    initial begin
        hold0 = '{32767, 32767};
        hold1 = '{32767, 32767};
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_gain_u0", int'(go0), int'({16'd32767, 16'd32767}));
        chk("reset_gain_u1", int'(go1), int'({16'd32767, 16'd32767}));
        chk("reset_valid", int'(gv0), 0);
        chk("reset_busy", int'(bz0), 0);

        strobe(0, 2'b01, 32767, 0, t);
        q0.push_back('{0, 29000, t + 33});
        repeat (40) @(posedge clk);

        strobe(0, 2'b10, 0, 0, t);
        q0.push_back('{1, 32767, t + 33});
        repeat (40) @(posedge clk);

        strobe(0, 2'b11, 40000, 50000, t);
        q0.push_back('{0, model(29000, 40000), t + 33});
        q0.push_back('{1, model(29000, 50000), t + 66});
        repeat (70) @(posedge clk);

        strobe(0, 2'b11, 60000, 65535, t);
        q0.push_back('{0, model(29000, 60000), t + 33});
        q0.push_back('{1, model(29000, 65535), t + 66});
        repeat (70) @(posedge clk);

        strobe(0, 2'b10, 0, 30000, t);
        q0.push_back('{1, model(29000, 30000), t + 33});
        q0.push_back('{0, model(29000, 40000), t + 66});
        repeat (3) @(posedge clk);
        strobe(0, 2'b01, 20000, 0, m0.cyc);
        repeat (2) @(posedge clk);
        strobe(0, 2'b01, 40000, 0, m0.cyc);
        repeat (70) @(posedge clk);

        strobe(0, 2'b01, 1000, 0, t);
        repeat (2) @(posedge clk);
        strobe(0, 2'b10, 0, 5000, m0.cyc);
        while (cyc < t + 11) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        hold0 = '{32767, 32767};
        chk("abort_busy", int'(bz0), 0);
        chk("abort_gain", int'(go0), int'({16'd32767, 16'd32767}));
        seen_busy = 0;
        repeat (80) begin
            @(negedge clk);
            seen_busy |= bz0;
        end
        chk("abort_no_pending", int'(seen_busy), 0);

        strobe(1, 2'b01, 65535, 0, t);
        q1.push_back('{0, 8192, t + 33});
        repeat (40) @(posedge clk);
        strobe(1, 2'b01, 8000, 0, t);
        q1.push_back('{0, 32767, t + 33});
        repeat (40) @(posedge clk);
        strobe(1, 2'b01, 32000, 0, t);
        q1.push_back('{0, model(8000, 32000), t + 33});

        for (int i = 0; i < 200 && (q0.size() + q1.size()) > 0; i++) @(posedge clk);
        chk("drain", q0.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
